// File: rtl/alu_share_arbiter_if.sv
// One requester port of alu_share_arbiter: request and response valid/ready handshakes.
// The shared result bus is a plain port on the arbiter, not part of this bundle.
interface alu_share_arbiter_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_in0;
   logic [31:0] req_in1;
   logic [2:0]  req_func3;
   logic        req_sub;
   logic        rsp_valid;
   logic        rsp_ready;

   modport master (
      output req_valid, req_in0, req_in1, req_func3, req_sub, rsp_ready,
      input  req_ready, rsp_valid
   );

   modport slave (
      input  req_valid, req_in0, req_in1, req_func3, req_sub, rsp_ready,
      output req_ready, rsp_valid
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, one operation in flight.
// IDLE -> EXEC (operands on ALU) -> RESP (result held for owner) -> IDLE.
module alu_share_arbiter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   alu_share_arbiter_if.slave    port_a,
   alu_share_arbiter_if.slave    port_b,
   output logic [31:0]           rsp_data,
   output logic [31:0]           alu_in0,
   output logic [31:0]           alu_in1,
   output logic [2:0]            alu_func3,
   output logic                  alu_sub,
   input  logic [31:0]           alu_out,
   output logic                  busy,
   output logic [CNT_W-1:0]      grant_cnt_a,
   output logic [CNT_W-1:0]      grant_cnt_b
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;
   typedef enum logic {PortA = 1'b0, PortB = 1'b1} port_e;

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

   state_e       state_q, state_d;
   port_e        owner_q, last_grant_q;
   logic [31:0]  in0_q, in1_q, rsp_data_q;
   logic [2:0]   func3_q;
   logic         sub_q;
   logic [CNT_W-1:0] cnt_a_q, cnt_b_q;

   logic grant_a, grant_b, accept_a, accept_b, owner_rsp_ready;

   // On a tie the port that did not win last time is granted.
   assign grant_a  = port_a.req_valid & (~port_b.req_valid | (last_grant_q == PortB));
   assign grant_b  = port_b.req_valid & (~port_a.req_valid | (last_grant_q == PortA));
   assign accept_a = (state_q == StIdle) & grant_a;
   assign accept_b = (state_q == StIdle) & grant_b;
   assign owner_rsp_ready = (owner_q == PortB) ? port_b.rsp_ready : port_a.rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept_a || accept_b) state_d = StExec;
         StExec:  state_d = StResp;
         StResp:  if (owner_rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      port_a.req_ready = 1'b0;
      port_b.req_ready = 1'b0;
      port_a.rsp_valid = 1'b0;
      port_b.rsp_valid = 1'b0;
      busy             = (state_q != StIdle);
      unique case (state_q)
         StIdle: begin
            port_a.req_ready = grant_a;
            port_b.req_ready = grant_b;
         end
         StResp: begin
            port_a.rsp_valid = (owner_q == PortA);
            port_b.rsp_valid = (owner_q == PortB);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in0_q        <= '0;
         in1_q        <= '0;
         func3_q      <= '0;
         sub_q        <= 1'b0;
         owner_q      <= PortA;
         last_grant_q <= PortB;
         rsp_data_q   <= '0;
         cnt_a_q      <= '0;
         cnt_b_q      <= '0;
      end else begin
         if (accept_b) begin
            in0_q        <= port_b.req_in0;
            in1_q        <= port_b.req_in1;
            func3_q      <= port_b.req_func3;
            sub_q        <= port_b.req_sub;
            owner_q      <= PortB;
            last_grant_q <= PortB;
            if (cnt_b_q != CntMax) cnt_b_q <= cnt_b_q + 1'b1;
         end else if (accept_a) begin
            in0_q        <= port_a.req_in0;
            in1_q        <= port_a.req_in1;
            func3_q      <= port_a.req_func3;
            sub_q        <= port_a.req_sub;
            owner_q      <= PortA;
            last_grant_q <= PortA;
            if (cnt_a_q != CntMax) cnt_a_q <= cnt_a_q + 1'b1;
         end
         if (state_q == StExec) rsp_data_q <= alu_out;
      end
   end

   assign alu_in0     = in0_q;
   assign alu_in1     = in1_q;
   assign alu_func3   = func3_q;
   assign alu_sub     = sub_q;
   assign rsp_data    = rsp_data_q;
   assign grant_cnt_a = cnt_a_q;
   assign grant_cnt_b = cnt_b_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a 16-bit-counter instance for function and arbitration,
// and a 2-bit-counter instance for saturation. The ALU is modelled combinationally here.
module tb_alu_share_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_share_arbiter_if port_a ();
   alu_share_arbiter_if port_b ();
   alu_share_arbiter_if sat_a ();
   alu_share_arbiter_if sat_b ();

   logic [31:0] rsp_data, alu_in0, alu_in1, alu_out;
   logic [2:0]  alu_func3;
   logic        alu_sub, busy;
   logic [15:0] cnt_a, cnt_b;

   logic [31:0] s_rsp_data, s_in0, s_in1, s_out;
   logic [2:0]  s_func3;
   logic        s_sub, s_busy;
   logic [1:0]  s_cnt_a, s_cnt_b;

   int checks = 0;
   int failures = 0;

   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f, input logic sub);
      case (f)
         3'b000:  return sub ? a - b : a + b;
         3'b001:  return a << b[4:0];
         3'b010:  return {31'd0, $signed(a) < $signed(b)};
         3'b011:  return {31'd0, a < b};
         3'b100:  return a ^ b;
         3'b101:  return sub ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'b110:  return a | b;
         default: return a & b;
      endcase
   endfunction

   assign alu_out = alu_fn(alu_in0, alu_in1, alu_func3, alu_sub);
   assign s_out   = alu_fn(s_in0, s_in1, s_func3, s_sub);

   alu_share_arbiter #(.CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .port_a(port_a), .port_b(port_b), .rsp_data(rsp_data),
      .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_func3(alu_func3), .alu_sub(alu_sub),
      .alu_out(alu_out), .busy(busy), .grant_cnt_a(cnt_a), .grant_cnt_b(cnt_b)
   );

   alu_share_arbiter #(.CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .port_a(sat_a), .port_b(sat_b), .rsp_data(s_rsp_data),
      .alu_in0(s_in0), .alu_in1(s_in1), .alu_func3(s_func3), .alu_sub(s_sub),
      .alu_out(s_out), .busy(s_busy), .grant_cnt_a(s_cnt_a), .grant_cnt_b(s_cnt_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full operation on port A (sel_b=0) or B (sel_b=1); that port's rsp_ready must be high.
   task automatic run_op(input string tag, input bit sel_b, input logic [31:0] in0,
                         input logic [31:0] in1, input logic [2:0] f3, input logic sub,
                         input logic [31:0] exp);
      if (sel_b) begin
         port_b.req_in0 = in0; port_b.req_in1 = in1; port_b.req_func3 = f3;
         port_b.req_sub = sub; port_b.req_valid = 1'b1;
      end else begin
         port_a.req_in0 = in0; port_a.req_in1 = in1; port_a.req_func3 = f3;
         port_a.req_sub = sub; port_a.req_valid = 1'b1;
      end
      #1;
      check({tag, " ready"}, 32'(sel_b ? port_b.req_ready : port_a.req_ready), 32'd1);
      step();
      port_a.req_valid = 1'b0;
      port_b.req_valid = 1'b0;
      check({tag, " exec busy"}, 32'(busy), 32'd1);
      check({tag, " exec no rsp"}, 32'(port_a.rsp_valid | port_b.rsp_valid), 32'd0);
      step();
      check({tag, " rsp_valid a"}, 32'(port_a.rsp_valid), 32'(!sel_b));
      check({tag, " rsp_valid b"}, 32'(port_b.rsp_valid), 32'(sel_b));
      check({tag, " rsp_data"}, rsp_data, exp);
      step();
      check({tag, " done idle"}, 32'(busy | port_a.rsp_valid | port_b.rsp_valid), 32'd0);
   endtask

   logic [1:0] sat_exp [5];

   initial begin
      port_a.req_valid = 0; port_a.req_in0 = 0; port_a.req_in1 = 0; port_a.req_func3 = 0;
      port_a.req_sub = 0; port_a.rsp_ready = 0;
      port_b.req_valid = 0; port_b.req_in0 = 0; port_b.req_in1 = 0; port_b.req_func3 = 0;
      port_b.req_sub = 0; port_b.rsp_ready = 0;
      sat_a.req_valid = 0; sat_a.req_in0 = 0; sat_a.req_in1 = 0; sat_a.req_func3 = 0;
      sat_a.req_sub = 0; sat_a.rsp_ready = 0;
      sat_b.req_valid = 0; sat_b.req_in0 = 0; sat_b.req_in1 = 0; sat_b.req_func3 = 0;
      sat_b.req_sub = 0; sat_b.rsp_ready = 0;
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      // Reset state
      step();
      step();
      check("reset busy", 32'(busy), 32'd0);
      check("reset rsp_valid", 32'(port_a.rsp_valid | port_b.rsp_valid), 32'd0);
      check("reset rsp_data", rsp_data, 32'd0);
      check("reset alu_func3", 32'(alu_func3), 32'd0);
      check("reset alu_sub", 32'(alu_sub), 32'd0);
      check("reset cnt_a", 32'(cnt_a), 32'd0);
      check("reset cnt_b", 32'(cnt_b), 32'd0);
      port_a.req_valid = 1'b1;
      port_b.req_valid = 1'b1;
      #1;
      check("reset tie ready_a", 32'(port_a.req_ready), 32'd1);
      check("reset tie ready_b", 32'(port_b.req_ready), 32'd0);
      port_a.req_valid = 1'b0;
      #1;
      check("reset solo ready_b", 32'(port_b.req_ready), 32'd1);
      port_b.req_valid = 1'b0;
      rst_n = 1'b1;
      step();

      // Single-port add
      port_a.rsp_ready = 1'b1;
      port_b.rsp_ready = 1'b1;
      run_op("add", 1'b0, 32'd5, 32'd7, 3'b000, 1'b0, 32'h0000_000C);
      check("add cnt_a", 32'(cnt_a), 32'd1);
      check("add cnt_b", 32'(cnt_b), 32'd0);

      // Tie and round-robin from reset
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      port_a.req_in0 = 32'd1; port_a.req_in1 = 32'd2; port_a.req_func3 = 3'b000;
      port_a.req_sub = 1'b0;
      port_b.req_in0 = 32'h8000_0000; port_b.req_in1 = 32'd4; port_b.req_func3 = 3'b101;
      port_b.req_sub = 1'b1;
      port_a.req_valid = 1'b1;
      port_b.req_valid = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("rr ready_a", 32'(port_a.req_ready), 32'(i % 2 == 0));
         check("rr ready_b", 32'(port_b.req_ready), 32'(i % 2 == 1));
         step();
         check("rr cnt_a", 32'(cnt_a), 32'((i + 2) / 2));
         check("rr cnt_b", 32'(cnt_b), 32'((i + 1) / 2));
         check("rr exec ready", 32'(port_a.req_ready | port_b.req_ready), 32'd0);
         step();
         check("rr rsp_valid a", 32'(port_a.rsp_valid), 32'(i % 2 == 0));
         check("rr rsp_valid b", 32'(port_b.rsp_valid), 32'(i % 2 == 1));
         check("rr rsp_data", rsp_data, (i % 2 == 0) ? 32'd3 : 32'hF800_0000);
         step();
      end
      port_a.req_valid = 1'b0;
      port_b.req_valid = 1'b0;

      // Response backpressure on A while B waits; B's rsp_ready is high but must be ignored
      port_a.rsp_ready = 1'b0;
      port_a.req_in0 = 32'd3; port_a.req_in1 = 32'd5; port_a.req_func3 = 3'b000;
      port_a.req_sub = 1'b1;
      port_a.req_valid = 1'b1;
      port_b.req_valid = 1'b1;
      #1;
      check("bp ready_a", 32'(port_a.req_ready), 32'd1);
      step();
      port_a.req_valid = 1'b0;
      step();
      for (int i = 0; i < 10; i++) begin
         check("bp rsp_data", rsp_data, 32'hFFFF_FFFE);
         check("bp rsp_valid_a", 32'(port_a.rsp_valid), 32'd1);
         check("bp busy", 32'(busy), 32'd1);
         check("bp ready_b", 32'(port_b.req_ready), 32'd0);
         step();
      end
      port_a.rsp_ready = 1'b1;
      step();
      check("bp release idle", 32'(busy), 32'd0);
      check("bp release ready_b", 32'(port_b.req_ready), 32'd1);
      check("bp release cnt_b", 32'(cnt_b), 32'd2);
      step();
      port_b.req_valid = 1'b0;
      check("bp b accepted cnt_b", 32'(cnt_b), 32'd3);
      check("bp b alu_in0", alu_in0, 32'h8000_0000);
      step();
      check("bp b rsp_data", rsp_data, 32'hF800_0000);
      check("bp b rsp_valid", 32'(port_b.rsp_valid), 32'd1);
      step();

      // SLTU and AND on B
      run_op("sltu", 1'b1, 32'd1, 32'hFFFF_FFFF, 3'b011, 1'b0, 32'h0000_0001);
      run_op("and", 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b111, 1'b0, 32'hF000_F000);
      check("and cnt_b", 32'(cnt_b), 32'd5);

      // Reset during EXEC
      port_a.req_in0 = 32'h1234_5678; port_a.req_in1 = 32'h1; port_a.req_func3 = 3'b001;
      port_a.req_sub = 1'b1;
      port_a.req_valid = 1'b1;
      step();
      port_a.req_valid = 1'b0;
      check("mrst exec busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mrst busy", 32'(busy), 32'd0);
      check("mrst alu_in0", alu_in0, 32'd0);
      check("mrst alu_in1", alu_in1, 32'd0);
      check("mrst alu_ctl", 32'({alu_func3, alu_sub}), 32'd0);
      check("mrst cnt_a", 32'(cnt_a), 32'd0);
      check("mrst cnt_b", 32'(cnt_b), 32'd0);
      check("mrst rsp_valid", 32'(port_a.rsp_valid | port_b.rsp_valid), 32'd0);
      step();
      rst_n = 1'b1;
      check("mrst held rsp_valid", 32'(port_a.rsp_valid | port_b.rsp_valid), 32'd0);
      step();
      check("mrst after rsp_valid", 32'(port_a.rsp_valid | port_b.rsp_valid | busy), 32'd0);
      run_op("mrst next", 1'b0, 32'h10, 32'h20, 3'b000, 1'b0, 32'h30);
      check("mrst next cnt_a", 32'(cnt_a), 32'd1);

      // Counter saturation on the 2-bit instance
      sat_a.req_in0 = 32'd1; sat_a.req_in1 = 32'd1;
      sat_a.rsp_ready = 1'b1;
      sat_a.req_valid = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         check("sat ready", 32'(sat_a.req_ready), 32'd1);
         step();
         check("sat cnt_a", 32'(s_cnt_a), 32'(sat_exp[i]));
         step();
         check("sat rsp_data", s_rsp_data, 32'd2);
         step();
      end
      sat_a.req_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
